// File: rtl/eprom_arbiter_pkg.sv
// Shared types and constants for the two-requester EPROM record fetcher.
package eprom_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;
    localparam int IDX_W  = 6;
    localparam int REC_W  = 16;

    // Nibble offsets inside a four-nibble record (value pair, then duration pair).
    localparam logic [1:0] OFF_V0 = 2'd0;
    localparam logic [1:0] OFF_V1 = 2'd1;
    localparam logic [1:0] OFF_T0 = 2'd2;
    localparam logic [1:0] OFF_T1 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Bit position of a nibble slot within the assembled record.
    function automatic logic [3:0] slot_lsb(input logic [1:0] off);
        case (off)
            OFF_V0:  return 4'd0;
            OFF_V1:  return 4'd4;
            OFF_T0:  return 4'd8;
            default: return 4'd12;
        endcase
    endfunction

endpackage

// File: rtl/eprom_arbiter_if.sv
// Requester handshakes plus the EPROM bus, bundled for the arbiter and its environment.
interface eprom_arbiter_if;
    import eprom_arb_pkg::*;

    logic              req0;
    logic              req1;
    logic [IDX_W-1:0]  idx0;
    logic [IDX_W-1:0]  idx1;
    logic              ack0;
    logic              ack1;
    logic [REC_W-1:0]  rec0;
    logic [REC_W-1:0]  rec1;
    logic [ADDR_W-1:0] addr;
    logic              s_;
    logic              mr_;
    logic [DATA_W-1:0] data;

    // The arbiter side: takes requests and EPROM data, returns records and drives the EPROM.
    modport slave (
        input  req0, req1, idx0, idx1, data,
        output ack0, ack1, rec0, rec1, addr, s_, mr_
    );

    // The environment side: requesters and the EPROM itself.
    modport master (
        output req0, req1, idx0, idx1, data,
        input  ack0, ack1, rec0, rec1, addr, s_, mr_
    );

endinterface

// File: rtl/eprom_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the favoured side.
module rr_arbiter_2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant_idx,
    output logic       grant_valid
);

    logic ptr;

    // Pick the winner combinationally; the pointer only breaks ties.
    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_idx = ptr;
        end else begin
            grant_idx = req[1];
        end
    end

    // After a grant actually taken, favour the other requester next time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (grant_en && grant_valid) begin
            ptr <= ~grant_idx;
        end
    end

endmodule

// File: rtl/eprom_arbiter.sv
// Shares one 256x4 EPROM between two requesters, fetching a four-nibble record per
// transaction and returning it over a 4-phase req/ack handshake.
module eprom_arbiter
    import eprom_arb_pkg::*;
#(
    // Cycles each address is held before its nibble is captured (1..4).
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clock,
    input  logic            reset,
    eprom_arbiter_if.slave  bus
);

    localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYCLES - 1);

    arb_state_t        state;
    logic              owner;
    logic [ADDR_W-1:0] addr_q;
    logic              s_q;
    logic              mr_q;
    logic [1:0]        ack_q;
    logic [REC_W-1:0]  rec0_q;
    logic [REC_W-1:0]  rec1_q;
    logic [1:0]        nib_cnt;
    logic [1:0]        wait_cnt;

    logic              grant_en;
    logic              grant_idx;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_rec_idx;
    logic              owner_req;
    logic              wait_last;
    logic              capture;

    assign grant_en      = (state == IDLE);
    assign grant_rec_idx = grant_idx ? bus.idx1 : bus.idx0;
    assign owner_req     = owner ? bus.req1 : bus.req0;
    assign wait_last     = (wait_cnt == WAIT_LAST);
    assign capture       = (state == READ) && wait_last;

    rr_arbiter_2 u_rr (
        .clock       (clock),
        .reset       (reset),
        .req         ({bus.req1, bus.req0}),
        .grant_en    (grant_en),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Transaction sequencing: grant, step through four nibble addresses, then hold ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            addr_q   <= '0;
            s_q      <= 1'b1;
            mr_q     <= 1'b1;
            ack_q    <= 2'b00;
            nib_cnt  <= OFF_V0;
            wait_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner    <= grant_idx;
                        addr_q   <= {grant_rec_idx, OFF_V0};
                        s_q      <= 1'b0;
                        mr_q     <= 1'b0;
                        nib_cnt  <= OFF_V0;
                        wait_cnt <= 2'd0;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (wait_last) begin
                        wait_cnt <= 2'd0;
                        if (nib_cnt == OFF_T1) begin
                            s_q          <= 1'b1;
                            mr_q         <= 1'b1;
                            addr_q       <= '0;
                            ack_q[owner] <= 1'b1;
                            state        <= DONE;
                        end else begin
                            addr_q[1:0] <= addr_q[1:0] + 2'd1;
                            nib_cnt     <= nib_cnt + 2'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (!owner_req) begin
                        ack_q <= 2'b00;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Drop each captured nibble into the owner's record; the other record is left alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rec0_q <= '0;
            rec1_q <= '0;
        end else if (capture) begin
            if (owner) begin
                rec1_q[slot_lsb(nib_cnt) +: DATA_W] <= bus.data;
            end else begin
                rec0_q[slot_lsb(nib_cnt) +: DATA_W] <= bus.data;
            end
        end
    end

    assign bus.addr = addr_q;
    assign bus.s_   = s_q;
    assign bus.mr_  = mr_q;
    assign bus.ack0 = ack_q[0];
    assign bus.ack1 = ack_q[1];
    assign bus.rec0 = rec0_q;
    assign bus.rec1 = rec1_q;

endmodule

// File: tb/tb_eprom_arbiter.sv
// Directed bench for eprom_arbiter: one instance with a 1-cycle wait, one with a 3-cycle wait,
// each backed by a model of the test EPROM.
module tb_eprom_arbiter;

    typedef struct {
        logic        who;
        logic [5:0]  idx;
        logic [15:0] rec;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    logic [15:0] exp_rec0;
    logic [15:0] exp_rec1;

    vec_t vecs [6];

    eprom_arbiter_if bus1 ();
    eprom_arbiter_if bus3 ();

    eprom_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    eprom_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    // Test EPROM contents: record i holds (i+1)%10, (i+1)%10, i%10, (i%9)+1.
    function automatic logic [3:0] rom_nibble(input logic [7:0] a);
        int i;
        i = int'(a[7:2]);
        case (a[1:0])
            2'd0, 2'd1: return 4'((i + 1) % 10);
            2'd2:       return 4'(i % 10);
            default:    return 4'((i % 9) + 1);
        endcase
    endfunction

    assign #1 bus1.data = (!bus1.s_ && !bus1.mr_) ? rom_nibble(bus1.addr) : 4'bx;
    assign #1 bus3.data = (!bus3.s_ && !bus3.mr_) ? rom_nibble(bus3.addr) : 4'bx;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset     = 1'b1;
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        bus3.req0 = 1'b0;
        bus3.req1 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset    = 1'b0;
        exp_rec0 = 16'h0;
        exp_rec1 = 16'h0;
    endtask

    // One complete single-requester transaction on the 1-cycle instance.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clock);
        if (v.who) begin
            bus1.idx1 = v.idx;
            bus1.req1 = 1'b1;
        end else begin
            bus1.idx0 = v.idx;
            bus1.req0 = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_output("addr_step", bus1.addr, {v.idx, 2'(k)});
            check_output("sel_low", {bus1.s_, bus1.mr_}, 2'b00);
            check_output("ack_early", v.who ? bus1.ack1 : bus1.ack0, 1'b0);
            if (k == 0) begin
                if (v.who) bus1.idx1 = ~v.idx;
                else       bus1.idx0 = ~v.idx;
            end
        end
        @(negedge clock);
        check_output("ack_rise", v.who ? bus1.ack1 : bus1.ack0, 1'b1);
        check_output("rec_value", v.who ? bus1.rec1 : bus1.rec0, v.rec);
        check_output("other_rec", v.who ? bus1.rec0 : bus1.rec1, v.who ? exp_rec0 : exp_rec1);
        check_output("other_ack", v.who ? bus1.ack0 : bus1.ack1, 1'b0);
        check_output("sel_high", {bus1.s_, bus1.mr_}, 2'b11);
        check_output("addr_park", bus1.addr, 8'h00);
        if (v.who) begin
            exp_rec1  = v.rec;
            bus1.req1 = 1'b0;
        end else begin
            exp_rec0  = v.rec;
            bus1.req0 = 1'b0;
        end
        @(negedge clock);
        check_output("ack_fall", v.who ? bus1.ack1 : bus1.ack0, 1'b0);
    endtask

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        exp_rec0  = 16'h0;
        exp_rec1  = 16'h0;
        reset     = 1'b1;
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        bus1.idx0 = 6'd0;
        bus1.idx1 = 6'd0;
        bus3.req0 = 1'b0;
        bus3.req1 = 1'b0;
        bus3.idx0 = 6'd0;
        bus3.idx1 = 6'd0;

        vecs[0] = '{who: 1'b0, idx: 6'd12, rec: 16'h4233};
        vecs[1] = '{who: 1'b1, idx: 6'd63, rec: 16'h1344};
        vecs[2] = '{who: 1'b0, idx: 6'd0,  rec: 16'h1011};
        vecs[3] = '{who: 1'b1, idx: 6'd5,  rec: 16'h6566};
        vecs[4] = '{who: 1'b0, idx: 6'd9,  rec: 16'h1900};
        vecs[5] = '{who: 1'b1, idx: 6'd44, rec: 16'h9455};

        // Reset held, then released with no request.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_output("rst_sel", {bus1.s_, bus1.mr_}, 2'b11);
        check_output("rst_addr", bus1.addr, 8'h00);
        check_output("rst_ack", {bus1.ack1, bus1.ack0}, 2'b00);
        check_output("rst_rec0", bus1.rec0, 16'h0);
        check_output("rst_rec1", bus1.rec1, 16'h0);
        check_output("rst_sel_w3", {bus3.s_, bus3.mr_}, 2'b11);
        check_output("rst_ack_w3", {bus3.ack1, bus3.ack0}, 2'b00);

        // Single-requester transactions from the vector table.
        for (int n = 0; n < 6; n++) begin
            apply_stimulus(vecs[n]);
        end

        // Simultaneous requests after reset: requester 0 wins, requester 1 waits.
        apply_reset();
        @(negedge clock);
        bus1.idx0 = 6'd0;
        bus1.idx1 = 6'd63;
        bus1.req0 = 1'b1;
        bus1.req1 = 1'b1;
        @(negedge clock);
        check_output("pair_first_addr", bus1.addr, 8'h00);
        repeat (2) @(negedge clock);
        @(negedge clock);
        check_output("pair_ack0_early", bus1.ack0, 1'b0);
        @(negedge clock);
        check_output("pair_ack0", bus1.ack0, 1'b1);
        check_output("pair_rec0", bus1.rec0, 16'h1011);
        check_output("pair_ack1_wait", bus1.ack1, 1'b0);
        check_output("pair_rec1_wait", bus1.rec1, 16'h0);
        bus1.req0 = 1'b0;
        @(negedge clock);
        check_output("pair_ack0_fall", bus1.ack0, 1'b0);
        check_output("pair_idle", {bus1.s_, bus1.mr_}, 2'b11);
        @(negedge clock);
        check_output("pair_second_addr", bus1.addr, 8'hFC);
        check_output("pair_second_sel", {bus1.s_, bus1.mr_}, 2'b00);
        repeat (3) @(negedge clock);
        check_output("pair_ack1_early", bus1.ack1, 1'b0);
        @(negedge clock);
        check_output("pair_ack1", bus1.ack1, 1'b1);
        check_output("pair_rec1", bus1.rec1, 16'h1344);
        check_output("pair_rec0_kept", bus1.rec0, 16'h1011);
        bus1.req1 = 1'b0;
        @(negedge clock);
        check_output("pair_ack1_fall", bus1.ack1, 1'b0);
        exp_rec0 = 16'h1011;
        exp_rec1 = 16'h1344;

        // A lone requester-0 grant hands priority to requester 1 for the next tie.
        apply_stimulus(vecs[0]);
        @(negedge clock);
        bus1.idx0 = 6'd9;
        bus1.idx1 = 6'd44;
        bus1.req0 = 1'b1;
        bus1.req1 = 1'b1;
        @(negedge clock);
        check_output("tie_first_addr", bus1.addr, 8'hB0);
        repeat (3) @(negedge clock);
        @(negedge clock);
        check_output("tie_ack1", bus1.ack1, 1'b1);
        check_output("tie_rec1", bus1.rec1, 16'h9455);
        check_output("tie_ack0_wait", bus1.ack0, 1'b0);
        bus1.req1 = 1'b0;
        @(negedge clock);
        check_output("tie_ack1_fall", bus1.ack1, 1'b0);
        @(negedge clock);
        check_output("tie_second_addr", bus1.addr, 8'h24);
        repeat (3) @(negedge clock);
        @(negedge clock);
        check_output("tie_ack0", bus1.ack0, 1'b1);
        check_output("tie_rec0", bus1.rec0, 16'h1900);
        bus1.req0 = 1'b0;
        @(negedge clock);
        check_output("tie_ack0_fall", bus1.ack0, 1'b0);

        // Reset in the middle of a read, then restart with the request still high.
        @(negedge clock);
        bus1.idx0 = 6'd12;
        bus1.req0 = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_output("midrst_addr_before", bus1.addr, 8'h31);
        reset = 1'b1;
        #1;
        check_output("midrst_sel", {bus1.s_, bus1.mr_}, 2'b11);
        check_output("midrst_addr", bus1.addr, 8'h00);
        check_output("midrst_ack", {bus1.ack1, bus1.ack0}, 2'b00);
        check_output("midrst_rec0", bus1.rec0, 16'h0);
        check_output("midrst_rec1", bus1.rec1, 16'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_output("restart_addr", bus1.addr, 8'h30);
        check_output("restart_sel", {bus1.s_, bus1.mr_}, 2'b00);
        repeat (3) @(negedge clock);
        @(negedge clock);
        check_output("restart_ack0", bus1.ack0, 1'b1);
        check_output("restart_rec0", bus1.rec0, 16'h4233);
        bus1.req0 = 1'b0;
        @(negedge clock);
        check_output("restart_ack0_fall", bus1.ack0, 1'b0);

        // Request withdrawn right after the grant: read still finishes, ack pulses once.
        @(negedge clock);
        bus1.idx0 = 6'd20;
        bus1.req0 = 1'b1;
        @(negedge clock);
        bus1.req0 = 1'b0;
        repeat (3) @(negedge clock);
        check_output("drop_ack_early", bus1.ack0, 1'b0);
        @(negedge clock);
        check_output("drop_ack_pulse", bus1.ack0, 1'b1);
        check_output("drop_rec0", bus1.rec0, 16'h3011);
        @(negedge clock);
        check_output("drop_ack_gone", bus1.ack0, 1'b0);
        @(negedge clock);
        check_output("drop_no_regrant", {bus1.s_, bus1.mr_}, 2'b11);

        // Three-cycle wait: every address held three cycles, ack twelve cycles after grant.
        @(negedge clock);
        bus3.idx1 = 6'd5;
        bus3.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clock);
                check_output("w3_addr", bus3.addr, {6'd5, 2'(k)});
                check_output("w3_ack_early", bus3.ack1, 1'b0);
            end
        end
        @(negedge clock);
        check_output("w3_ack1", bus3.ack1, 1'b1);
        check_output("w3_rec1", bus3.rec1, 16'h6566);
        check_output("w3_rec0_kept", bus3.rec0, 16'h0);
        check_output("w3_sel_high", {bus3.s_, bus3.mr_}, 2'b11);
        bus3.req1 = 1'b0;
        @(negedge clock);
        check_output("w3_ack1_fall", bus3.ack1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
